// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte producers with
//   round-robin arbitration. One byte is accepted per grant. The block then
//   issues a single start pulse to the UART core, waits for its completion
//   pulse, and reports completion back to the requester that owned the frame.
//
//   Optional feature macro: UART_ARB_TIMEOUT_EN
//     When defined, a watchdog abandons a frame whose tx_done has not arrived
//     within TIMEOUT_CYCLES cycles of WAIT and pulses err_timeout.
//     When undefined, WAIT holds until tx_done and err_timeout is constant 0.
//
// Ports
//   clk          in   1                  system clock, rising edge
//   rst_n        in   1                  asynchronous active-low reset
//   req_valid    in   NUM_REQ            requester i has a byte pending
//   req_data     in   NUM_REQ*DATA_BITS  byte of requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready    out  NUM_REQ            one-hot accept pulse, byte captured this cycle
//   req_done     out  NUM_REQ            one-hot pulse, owner's byte has left the line
//   tx_start     out  1                  one-cycle start pulse to the UART core
//   tx_data      out  DATA_BITS          byte to the UART core (held until next grant)
//   tx_done      in   1                  one-cycle completion pulse from the UART core
//   busy         out  1                  FSM is not IDLE
//   grant_id     out  IDW                index of the current/last owner
//   err_timeout  out  1                  one-cycle watchdog pulse
//   dbg_state    out  2                  raw FSM state (IDLE=0, START=1, WAIT=2)
//
// Handshake: a byte transfers from requester i in any cycle where
//   req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and
//   only ever asserted in IDLE, so a requester must hold valid and data stable
//   until it sees ready; dropping valid earlier withdraws the request.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             req_done,
   output logic                           tx_start,
   output logic [DATA_BITS-1:0]           tx_data,
   input  logic                           tx_done,
   output logic                           busy,
   output logic [IDW-1:0]                 grant_id,
   output logic                           err_timeout,
   output logic [1:0]                     dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]           r_state;
   logic [IDW-1:0]       r_rr_ptr;
   logic [IDW-1:0]       r_grant_id;
   logic [DATA_BITS-1:0] r_data;

   logic                 w_found;
   logic [IDW-1:0]       w_winner;
   logic [IDW-1:0]       w_next_ptr;
   logic [IDW:0]         w_sum;
   logic [IDW-1:0]       w_idx;
   logic [DATA_BITS-1:0] w_sel_data;
   logic [NUM_REQ-1:0]   w_win_oh;
   logic [NUM_REQ-1:0]   w_grant_oh;
   logic                 w_timeout;

   // Round-robin search: visit rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ, and
   // take the first asserted request. The extra sum bit makes the wrap work
   // for non-power-of-two NUM_REQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDW+1)'(NUM_REQ);
         end
         w_idx = w_sum[IDW-1:0];
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Mux the winner's byte with constant slice positions.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == IDW'(i)) begin
            w_sel_data = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   assign w_next_ptr = (w_winner == IDW'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;
   assign w_win_oh   = NUM_REQ'(1) << w_winner;
   assign w_grant_oh = NUM_REQ'(1) << r_grant_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_data     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_data     <= w_sel_data;
                  r_grant_id <= w_winner;
                  r_rr_ptr   <= w_next_ptr;
                  r_state    <= S_START;
               end
            end
            S_START: r_state <= S_WAIT;
            S_WAIT: begin
               // tx_done takes priority over the watchdog (w_timeout is
               // already qualified with !tx_done).
               if (tx_done || w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Counts cycles spent in WAIT; cleared while in START so that the first
   // WAIT cycle sees 0. It never passes TIMEOUT_CYCLES-1 because the watchdog
   // leaves WAIT at that value.
   logic [CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_START) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == S_WAIT) && !tx_done &&
                      (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES-1));
`else
   // Watchdog compiled out. The comparison is constant 0; it keeps the
   // parameter referenced so both builds share one parameter list.
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   assign req_ready   = ((r_state == S_IDLE) && w_found) ? w_win_oh : '0;
   assign req_done    = ((r_state == S_WAIT) && tx_done) ? w_grant_oh : '0;
   assign tx_start    = (r_state == S_START);
   assign tx_data     = r_data;
   assign busy        = (r_state != S_IDLE);
   assign grant_id    = r_grant_id;
   assign err_timeout = w_timeout;
   assign dbg_state   = r_state;

endmodule
